uf_sequencer: RTL and testbench
===============================

UF_SEQUENCER -- requirements
Module: uf_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_NODE_COUNT, default 2000, giving the number of union-find nodes; localparam INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port clear, input, 1 bit: request a union-find wipe, honoured only in IDLE.
REQ-005 The block SHALL have ports edge_valid (input, 1), edge_ready (output, 1), edge_pair (input, uf_edge_t {u,v}) and edge_last (input, 1), forming an upstream edge stream; edge_last marks the final pair of a batch.
REQ-006 The block SHALL have ports uf_rst (output, 1), uf_in_valid (output, 1), uf_in_metadata (output, uf_edge_t), uf_in_ready (input, 1), uf_out_index (output, INDEX_BIT_WIDTH), uf_out_valid (input, 1), uf_out_is_root (input, 1) and uf_out_size (input, INDEX_BIT_WIDTH); these drive one union_find instance.
REQ-007 The block SHALL have ports res_valid (output, 1), res_ready (input, 1), res_product (output, 3*INDEX_BIT_WIDTH) and res_roots (output, INDEX_BIT_WIDTH+1), forming the result handshake.

Function
REQ-010 The FSM SHALL have states IDLE, WIPE, ARM, FEED, DRAIN, SCAN and DONE.
REQ-011 In IDLE with clear=1, the block SHALL assert uf_rst for exactly one cycle (WIPE), then return to IDLE; clear has priority over edge_valid.
REQ-012 In IDLE, edge_ready=1; on edge_valid, the block SHALL capture the pair and edge_last into pair_reg/last_reg and go to ARM.
REQ-013 From ARM through FEED, uf_in_valid=1 and uf_in_metadata=pair_reg continuously.
REQ-014 A pair is committed on any cycle with uf_in_valid and uf_in_ready both high; ARM SHALL move to FEED on the first commit.
REQ-015 In FEED, edge_ready = uf_in_ready AND NOT last_reg; each accepted edge SHALL overwrite pair_reg/last_reg on that edge, so every pair is presented for at least one commit cycle.
REQ-016 During upstream bubbles in FEED, the block SHALL keep uf_in_valid high and re-present pair_reg; duplicate commits are idempotent and required.
REQ-017 FEED SHALL go to DRAIN on a commit with last_reg=1; in DRAIN, uf_in_valid=0.
REQ-018 DRAIN SHALL set a sticky flag when uf_out_valid=0 and enter SCAN on the first uf_out_valid=1 after the flag; the flag clears on leaving DRAIN.
REQ-019 SCAN SHALL step scan_idx 0..MAX_NODE_COUNT-1, one index per cycle, with uf_out_index=scan_idx; it SHALL sample uf_out_is_root and uf_out_size the same cycle.
REQ-020 For each root, the block SHALL increment the root count and insert the size into top-3 registers t0>=t1>=t2; a size equal to an existing entry is placed below it.
REQ-021 After index MAX_NODE_COUNT-1, res_product SHALL equal t0*t1*t2 at full 3*INDEX_BIT_WIDTH width, with unfilled slots counted as 1; res_roots SHALL equal the root count; the block SHALL then enter DONE.
REQ-022 In DONE, res_valid=1 and the outputs SHALL be held stable until res_ready; on handshake the block SHALL return to IDLE.
REQ-023 Union-find state SHALL accumulate across batches unless clear is issued.
REQ-024 uf_out_index SHALL be 0 outside SCAN.

Reset
REQ-030 When rst=1, the block SHALL enter IDLE and clear scan_idx, the counters, t0..t2, the DRAIN flag, pair_reg and last_reg.
REQ-031 When rst=1, uf_rst SHALL equal 1 combinationally (rst OR the wipe pulse), and all other outputs SHALL be 0.
REQ-032 A reset in any state, including mid-FEED or mid-SCAN, SHALL abandon the batch with no result emitted.

Structure
REQ-040 uf_edge_t {u,v} and the INDEX_BIT_WIDTH function SHALL live in package uf_pkg, shared with union_find.
REQ-041 The top-3 insertion logic SHALL be a sub-module, uf_top3_tracker, with ports clear, in_valid, in_size, t0, t1 and t2.

Verification (bench drives the uf_* side with a scripted responder, MAX_NODE_COUNT=8)
REQ-050 Single edge {0,1} with last=1 -> uf_in_valid high from ARM; exactly one FEED commit; uf_in_valid falls; DRAIN waits out a 3-cycle uf_out_valid low.
REQ-051 Three edges with 2-cycle upstream gaps -> uf_in_valid never drops before last; the pair is held during the gaps; each pair committed at least once.
REQ-052 SCAN with roots {0:size 5, 3:size 2, 6:size 1} -> res_product=10, res_roots=3, res_valid held until res_ready.
REQ-053 SCAN with tied sizes {4,4,4,2} -> res_product=64; single root size 8 -> res_product=8, res_roots=1.
REQ-054 clear in IDLE concurrent with edge_valid -> one-cycle uf_rst, edge_ready=0 that cycle, edge accepted the next IDLE cycle.
REQ-055 rst asserted mid-SCAN (scan_idx=4) -> next cycle IDLE, res_valid=0, uf_rst=1 during reset, and a fresh batch completes normally.

Source files
------------

// File: rtl/uf_pkg.sv
// Shared union-find types: the edge payload, the index-width helper and the
// sequencer state encoding. Edge endpoints are sized for the largest
// supported forest so the union_find instance and its drivers agree.
package uf_pkg;

  // Bits needed to address n nodes (at least one bit).
  function automatic int unsigned index_bit_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned UF_MAX_NODES = 2000;
  localparam int unsigned UF_IDX_W     = index_bit_width(UF_MAX_NODES);

  typedef struct packed {
    logic [UF_IDX_W-1:0] u;
    logic [UF_IDX_W-1:0] v;
  } uf_edge_t;

  typedef enum logic [2:0] {
    IDLE,
    WIPE,
    ARM,
    FEED,
    DRAIN,
    SCAN,
    DONE
  } uf_seq_state_e;

endpackage

// File: rtl/uf_top3_tracker.sv
// Keeps the three largest component sizes seen since the last clear.
// Ports: clk; clear (sync wipe to empty); in_valid/in_size (one candidate
// per cycle); t0 >= t1 >= t2 (zero means the slot is still empty).
module uf_top3_tracker #(
  parameter int unsigned SIZE_W = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [SIZE_W-1:0] in_size,
  output logic [SIZE_W-1:0] t0,
  output logic [SIZE_W-1:0] t1,
  output logic [SIZE_W-1:0] t2
);

  // Strict compares so a tie lands below the existing equal entry.
  always_ff @(posedge clk) begin
    if (clear) begin
      t0 <= '0;
      t1 <= '0;
      t2 <= '0;
    end else if (in_valid) begin
      if (in_size > t0) begin
        t0 <= in_size;
        t1 <= t0;
        t2 <= t1;
      end else if (in_size > t1) begin
        t1 <= in_size;
        t2 <= t1;
      end else if (in_size > t2) begin
        t2 <= in_size;
      end
    end
  end

endmodule

// File: rtl/uf_sequencer.sv
// Feeds an edge batch into a union_find instance, waits for it to settle,
// then scans every node and reports the root count and the product of the
// three largest component sizes.
// Ports: clk, rst (sync, active-high), clear (wipe request, IDLE only);
// edge_valid/edge_ready/edge_pair/edge_last (upstream batch);
// uf_rst, uf_in_valid/uf_in_ready/uf_in_metadata, uf_out_index,
// uf_out_valid/uf_out_is_root/uf_out_size (union_find side);
// res_valid/res_ready/res_product/res_roots (result).
module uf_sequencer
  import uf_pkg::*;
#(
  parameter int unsigned MAX_NODE_COUNT = 2000,
  localparam int unsigned INDEX_BIT_WIDTH = index_bit_width(MAX_NODE_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         edge_valid,
  output logic                         edge_ready,
  input  uf_edge_t                     edge_pair,
  input  logic                         edge_last,
  output logic                         uf_rst,
  output logic                         uf_in_valid,
  output uf_edge_t                     uf_in_metadata,
  input  logic                         uf_in_ready,
  output logic [INDEX_BIT_WIDTH-1:0]   uf_out_index,
  input  logic                         uf_out_valid,
  input  logic                         uf_out_is_root,
  input  logic [INDEX_BIT_WIDTH-1:0]   uf_out_size,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3*INDEX_BIT_WIDTH-1:0] res_product,
  output logic [INDEX_BIT_WIDTH:0]     res_roots
);

  localparam int unsigned SIZE_W = INDEX_BIT_WIDTH + 1;
  localparam int unsigned PROD_W = 3 * INDEX_BIT_WIDTH;
  localparam int unsigned FULL_W = 3 * SIZE_W;
  localparam logic [INDEX_BIT_WIDTH-1:0] LAST_IDX = INDEX_BIT_WIDTH'(MAX_NODE_COUNT - 1);

  uf_seq_state_e               state;
  uf_edge_t                    pair_reg;
  logic                        last_reg;
  logic                        drain_seen;
  logic [INDEX_BIT_WIDTH-1:0]  scan_idx;
  logic [SIZE_W-1:0]           root_cnt;

  logic                        feeding;
  logic                        scanning;
  logic                        done;
  logic [SIZE_W-1:0]           eff_size;
  logic [SIZE_W-1:0]           t0, t1, t2;
  logic [SIZE_W-1:0]           f0, f1, f2;
  logic [FULL_W-1:0]           prod_full;

  assign feeding  = (state == ARM) || (state == FEED);
  assign scanning = (state == SCAN);
  assign done     = (state == DONE);

  // A root always has size >= 1, so an all-zero size field can only be a
  // tree spanning every node whose size wrapped out of the index width.
  assign eff_size = (uf_out_size == '0) ? SIZE_W'(MAX_NODE_COUNT) : {1'b0, uf_out_size};

  uf_top3_tracker #(
    .SIZE_W (SIZE_W)
  ) u_top3 (
    .clk      (clk),
    .clear    (rst || !(scanning || done)),
    .in_valid (scanning && uf_out_is_root),
    .in_size  (eff_size),
    .t0       (t0),
    .t1       (t1),
    .t2       (t2)
  );

  // Empty slots contribute a factor of one.
  assign f0 = (t0 == '0) ? SIZE_W'(1) : t0;
  assign f1 = (t1 == '0) ? SIZE_W'(1) : t1;
  assign f2 = (t2 == '0) ? SIZE_W'(1) : t2;
  assign prod_full = FULL_W'(f0) * FULL_W'(f1) * FULL_W'(f2);

  // Sequencer FSM and its datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pair_reg   <= '0;
      last_reg   <= 1'b0;
      drain_seen <= 1'b0;
      scan_idx   <= '0;
      root_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state <= WIPE;
          end else if (edge_valid) begin
            pair_reg <= edge_pair;
            last_reg <= edge_last;
            state    <= ARM;
          end
        end
        WIPE: state <= IDLE;
        ARM: begin
          if (uf_in_ready) state <= FEED;
        end
        FEED: begin
          // The current pair commits on the same edge a new one is taken.
          if (edge_valid && uf_in_ready && !last_reg) begin
            pair_reg <= edge_pair;
            last_reg <= edge_last;
          end
          if (uf_in_ready && last_reg) state <= DRAIN;
        end
        DRAIN: begin
          // Require a low-then-high on uf_out_valid so stale validity from
          // before the final commit is never mistaken for settled output.
          if (!uf_out_valid) begin
            drain_seen <= 1'b1;
          end else if (drain_seen) begin
            drain_seen <= 1'b0;
            scan_idx   <= '0;
            root_cnt   <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (uf_out_is_root) root_cnt <= root_cnt + SIZE_W'(1);
          if (scan_idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            scan_idx <= scan_idx + INDEX_BIT_WIDTH'(1);
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register; reset forces everything but uf_rst low.
  assign uf_rst         = rst || (state == WIPE);
  assign edge_ready     = !rst && (((state == IDLE) && !clear) ||
                                   ((state == FEED) && uf_in_ready && !last_reg));
  assign uf_in_valid    = !rst && feeding;
  assign uf_in_metadata = (!rst && feeding) ? pair_reg : '0;
  assign uf_out_index   = (!rst && scanning) ? scan_idx : '0;
  assign res_valid      = !rst && done;
  assign res_product    = (!rst && done) ? PROD_W'(prod_full) : '0;
  assign res_roots      = (!rst && done) ? root_cnt : '0;

endmodule

// File: tb/tb_uf_sequencer.sv
// Directed bench for uf_sequencer with a scripted union_find responder.
module tb_uf_sequencer;
  import uf_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef int size_arr_t [N];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic edge_valid = 1'b0;
  logic edge_last = 1'b0;
  logic uf_in_ready = 1'b1;
  logic uf_out_valid = 1'b0;
  logic res_ready = 1'b0;
  uf_edge_t edge_pair = '0;

  logic           uf_rst, edge_ready, uf_in_valid, res_valid, uf_out_is_root;
  uf_edge_t       uf_in_metadata;
  logic [W-1:0]   uf_out_index, uf_out_size;
  logic [3*W-1:0] res_product;
  logic [W:0]     res_roots;

  bit root_tbl [N];
  int size_tbl [N];

  int n_cmp = 0;
  int n_bad = 0;
  uf_edge_t sent_q[$];
  uf_edge_t commit_q[$];
  logic prev_iv = 1'b0;

  uf_sequencer #(.MAX_NODE_COUNT(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .edge_valid     (edge_valid),
    .edge_ready     (edge_ready),
    .edge_pair      (edge_pair),
    .edge_last      (edge_last),
    .uf_rst         (uf_rst),
    .uf_in_valid    (uf_in_valid),
    .uf_in_metadata (uf_in_metadata),
    .uf_in_ready    (uf_in_ready),
    .uf_out_index   (uf_out_index),
    .uf_out_valid   (uf_out_valid),
    .uf_out_is_root (uf_out_is_root),
    .uf_out_size    (uf_out_size),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_product    (res_product),
    .res_roots      (res_roots)
  );

  always #5 clk = ~clk;

  // Responder: a full-tree size of N does not fit in W bits and wraps to 0.
  assign uf_out_is_root = root_tbl[uf_out_index];
  assign uf_out_size    = W'(size_tbl[uf_out_index]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_roots(input size_arr_t sz);
    for (int i = 0; i < N; i++) begin
      root_tbl[i] = (sz[i] != 0);
      size_tbl[i] = sz[i];
    end
  endtask

  // Model: sort root sizes descending, multiply the top three.
  function automatic longint model_product();
    int s[$];
    longint p = 1;
    for (int i = 0; i < N; i++) if (root_tbl[i]) s.push_back(size_tbl[i]);
    s.rsort();
    for (int i = 0; i < 3; i++) if (i < s.size()) p = p * s[i];
    return p;
  endfunction

  function automatic int model_roots();
    int c = 0;
    for (int i = 0; i < N; i++) if (root_tbl[i]) c++;
    return c;
  endfunction

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_uf_rst", 64'(uf_rst), 64'(1));
      check("rst_outputs_zero", 64'({edge_ready, uf_in_valid, uf_in_metadata, uf_out_index,
                                     res_valid, res_product, res_roots}), 64'(0));
      prev_iv = 1'b0;
    end else begin
      if (uf_in_valid && uf_in_ready) commit_q.push_back(uf_in_metadata);
      if (prev_iv && !uf_in_valid && sent_q.size() > 0 && commit_q.size() > 0)
        check("feed_until_last", 64'(commit_q[$]), 64'(sent_q[$]));
      if (res_valid) begin
        check("res_product_model", 64'(res_product), 64'(model_product()));
        check("res_roots_model", 64'(res_roots), 64'(model_roots()));
      end
      prev_iv = uf_in_valid;
    end
  end

  task automatic send_edge(input int u, input int v, input bit last);
    bit accepted = 1'b0;
    edge_pair.u = UF_IDX_W'(u);
    edge_pair.v = UF_IDX_W'(v);
    edge_last   = last;
    edge_valid  = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (edge_ready) accepted = 1'b1;
      tick();
    end
    edge_valid = 1'b0;
    edge_last  = 1'b0;
    check("edge_accept", 64'(accepted), 64'(1));
    sent_q.push_back(edge_pair);
  endtask

  task automatic hold_gap(input int cycles, input uf_edge_t exp_pair);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("gap_in_valid", 64'(uf_in_valid), 64'(1));
      check("gap_pair_held", 64'(uf_in_metadata), 64'(exp_pair));
      tick();
    end
  endtask

  task automatic wait_drain();
    int cyc = 0;
    @(negedge clk);
    while (uf_in_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_reached", 64'(uf_in_valid), 64'(0));
  endtask

  task automatic finish_batch(input longint exp_p, input int exp_r);
    uf_edge_t d[$];
    wait_drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("drain_wait", 64'({uf_in_valid, res_valid, uf_out_index}), 64'(0));
    end
    tick();
    uf_out_valid = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("scan_index", 64'(uf_out_index), 64'(i));
      tick();
    end
    uf_out_valid = 1'b0;
    @(negedge clk);
    check("res_valid_done", 64'(res_valid), 64'(1));
    check("res_product", 64'(res_product), 64'(exp_p));
    check("res_roots", 64'(res_roots), 64'(exp_r));
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check("res_hold", 64'({res_valid, res_product, res_roots}),
            64'({1'b1, 9'(exp_p), 4'(exp_r)}));
    end
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    check("res_release", 64'(res_valid), 64'(0));
    check("idle_ready", 64'(edge_ready), 64'(1));
    foreach (commit_q[i]) if (d.size() == 0 || d[$] != commit_q[i]) d.push_back(commit_q[i]);
    check("commit_count", 64'(d.size()), 64'(sent_q.size()));
    for (int i = 0; i < d.size() && i < sent_q.size(); i++)
      check("commit_order", 64'(d[i]), 64'(sent_q[i]));
  endtask

  task automatic clear_logs();
    sent_q.delete();
    commit_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    set_roots('{5, 0, 0, 2, 0, 0, 1, 0});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_edge_ready", 64'(edge_ready), 64'(1));
    check("idle_uf_rst", 64'(uf_rst), 64'(0));
    check("idle_quiet", 64'({uf_in_valid, res_valid, uf_out_index}), 64'(0));

    // Single edge, last in batch.
    tick();
    send_edge(0, 1, 1'b1);
    @(negedge clk);
    check("arm_in_valid", 64'(uf_in_valid), 64'(1));
    check("arm_pair", 64'(uf_in_metadata), 64'({11'd0, 11'd1}));
    finish_batch(10, 3);
    check("single_edge_commits", 64'(commit_q.size()), 64'(2));
    clear_logs();

    // Three edges with upstream gaps, tied sizes.
    set_roots('{0, 4, 4, 0, 0, 4, 0, 2});
    tick();
    send_edge(2, 3, 1'b0);
    hold_gap(2, sent_q[$]);
    send_edge(4, 5, 1'b0);
    hold_gap(2, sent_q[$]);
    send_edge(6, 7, 1'b1);
    finish_batch(64, 4);
    clear_logs();

    // One tree spanning every node.
    set_roots('{0, 0, 0, 0, 8, 0, 0, 0});
    tick();
    send_edge(0, 7, 1'b1);
    finish_batch(8, 1);
    clear_logs();

    // clear concurrent with edge_valid in IDLE.
    set_roots('{5, 0, 0, 2, 0, 0, 1, 0});
    tick();
    clear = 1'b1;
    edge_valid = 1'b1;
    edge_pair.u = UF_IDX_W'(3);
    edge_pair.v = UF_IDX_W'(4);
    edge_last = 1'b1;
    @(negedge clk);
    check("clear_blocks_ready", 64'(edge_ready), 64'(0));
    check("wipe_not_yet", 64'(uf_rst), 64'(0));
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("wipe_pulse", 64'(uf_rst), 64'(1));
    check("wipe_ready", 64'(edge_ready), 64'(0));
    tick();
    @(negedge clk);
    check("wipe_one_cycle", 64'(uf_rst), 64'(0));
    check("accept_after_wipe", 64'(edge_ready), 64'(1));
    tick();
    edge_valid = 1'b0;
    edge_last = 1'b0;
    sent_q.push_back(edge_pair);
    @(negedge clk);
    check("arm_after_wipe", 64'(uf_in_valid), 64'(1));
    finish_batch(10, 3);
    clear_logs();

    // Reset in the middle of a scan.
    tick();
    send_edge(1, 2, 1'b1);
    wait_drain();
    tick();
    tick();
    uf_out_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    check("scan_idx_before_rst", 64'(uf_out_index), 64'(4));
    #1;
    rst = 1'b1;
    uf_out_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_scan_uf_rst", 64'(uf_rst), 64'(1));
    check("rst_mid_scan_res", 64'(res_valid), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst_ready", 64'(edge_ready), 64'(1));
    check("idle_after_rst_quiet", 64'({res_valid, uf_out_index, uf_in_valid}), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("no_result_after_rst", 64'(seen), 64'(0));
    clear_logs();

    // Fresh batch after the abandoned one.
    set_roots('{0, 4, 4, 0, 0, 4, 0, 2});
    tick();
    send_edge(5, 6, 1'b1);
    finish_batch(64, 4);
    clear_logs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
